// File: rtl/sseg_pkg.sv
// Shared encodings for the seven-segment scan multiplexer: hex glyph table,
// blank encodings and segment bit positions {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int MAX_DIGITS = 16;

  localparam logic [7:0]            SEG_OFF    = 8'hFF;
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = 16'hFFFF;

  // Active-low glyphs with the decimal point off; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] HEX_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    DRIVE_BLANK = 1'b0,
    DRIVE_DIGIT = 1'b1
  } drive_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] glyph;
    glyph = HEX_TABLE[nibble];
    return glyph[SEG_G:SEG_A];
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble to active-low seven-segment lookup (segments g..a).
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Double-buffered seven-segment scan multiplexer for common-anode displays.
// Optional build macro SSEG_DIM_EN adds a 4-bit brightness input (PWM per slot).
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SSEG_DIM_EN
  input  logic [3:0]              bright,
`endif
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW       = $clog2(NUM_DIGITS);
  localparam int DIM_STEP = REFRESH_DIV / 16;

  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [IW-1:0] index_reg, index_next;
  logic          slot_tick;
  logic          frame_wrap;
  logic          wrap_d_reg;
  logic          frame_tick_reg;

  logic [4*NUM_DIGITS-1:0] stage_digits_reg, act_digits_reg;
  logic [NUM_DIGITS-1:0]   stage_dp_reg,     act_dp_reg;
  logic [NUM_DIGITS-1:0]   stage_en_reg,     act_en_reg;
  logic                    pending_reg;

  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_en;
  logic [6:0]            cur_seg;
  logic                  in_window;
  drive_t                drive_mode;

  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [7:0]            sseg_reg, sseg_next;

  // ---------------- slot prescaler and digit index ----------------
  assign slot_tick  = (prescaler_reg == PW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_tick && (index_reg == IW'(NUM_DIGITS - 1));

  always_comb begin
    prescaler_next = prescaler_reg + PW'(1);
    index_next     = index_reg;
    if (slot_tick) begin
      prescaler_next = '0;
      index_next     = (index_reg == IW'(NUM_DIGITS - 1)) ? '0 : index_reg + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_reg <= '0;
      index_reg     <= '0;
    end else begin
      prescaler_reg <= prescaler_next;
      index_reg     <= index_next;
    end
  end

  // ---------------- staging / active double buffer ----------------
  // A load landing on the wrap itself bypasses staging so it is not lost for a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_digits_reg <= '0;
      stage_dp_reg     <= '0;
      stage_en_reg     <= '0;
      act_digits_reg   <= '0;
      act_dp_reg       <= '0;
      act_en_reg       <= '0;
      pending_reg      <= 1'b0;
    end else begin
      if (load) begin
        stage_digits_reg <= digits;
        stage_dp_reg     <= dp;
        stage_en_reg     <= digit_en;
      end
      if (frame_wrap && load) begin
        act_digits_reg <= digits;
        act_dp_reg     <= dp;
        act_en_reg     <= digit_en;
        pending_reg    <= 1'b0;
      end else if (frame_wrap && pending_reg) begin
        act_digits_reg <= stage_digits_reg;
        act_dp_reg     <= stage_dp_reg;
        act_en_reg     <= stage_en_reg;
        pending_reg    <= 1'b0;
      end else if (load) begin
        pending_reg <= 1'b1;
      end
    end
  end

`ifdef SSEG_DIM_EN
  logic [3:0]  stage_bright_reg, act_bright_reg;
  logic [31:0] window_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_bright_reg <= '0;
      act_bright_reg   <= '0;
    end else begin
      if (load) begin
        stage_bright_reg <= bright;
      end
      if (frame_wrap && load) begin
        act_bright_reg <= bright;
      end else if (frame_wrap && pending_reg) begin
        act_bright_reg <= stage_bright_reg;
      end
    end
  end

  // Full brightness is forced so a REFRESH_DIV that is not a multiple of 16 still lights the whole slot.
  always_comb begin
    window_len = (32'(act_bright_reg) + 32'd1) * 32'(DIM_STEP);
    in_window  = (act_bright_reg == 4'hF) || (32'(prescaler_reg) < window_len);
  end
`else
  assign in_window = 1'b1;
`endif

  // ---------------- current digit selection ----------------
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign sel_onehot[gi] = (index_reg == IW'(gi));
  end

  always_comb begin
    cur_nibble = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_onehot[i]) begin
        cur_nibble = act_digits_reg[4*i +: 4];
      end
    end
  end

  assign cur_dp = |(act_dp_reg & sel_onehot);
  assign cur_en = |(act_en_reg & sel_onehot);

  sseg_hex_decoder u_hex_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // ---------------- registered output stage ----------------
  always_comb begin
    drive_mode = (cur_en && in_window) ? DRIVE_DIGIT : DRIVE_BLANK;
    an_next    = ANODES_OFF[NUM_DIGITS-1:0];
    sseg_next  = SEG_OFF;
    if (drive_mode == DRIVE_DIGIT) begin
      an_next   = ~sel_onehot;
      sseg_next = {~cur_dp, cur_seg};
    end
  end

  // frame_tick is delayed twice so it lines up with digit 0 reaching the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_reg         <= ANODES_OFF[NUM_DIGITS-1:0];
      sseg_reg       <= SEG_OFF;
      wrap_d_reg     <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      sseg_reg       <= sseg_next;
      wrap_d_reg     <= frame_wrap;
      frame_tick_reg <= wrap_d_reg;
    end
  end

  assign an         = an_reg;
  assign sseg       = sseg_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Parametrised, double-buffered seven-segment scan multiplexer for the board's common-anode displays.
- Cycles through NUM_DIGITS digits, one every REFRESH_DIV clocks.
- Decodes each hex nibble to active-low segments, with per-digit decimal point and blanking.
- New display data is latched only at frame boundaries, so updates never tear mid-scan.
- Sits between the lift controller's floor/status logic and the FPGA pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 2..16.
- REFRESH_DIV, 100000: clocks per digit slot; minimum 16.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex nibbles; digit i is [4i+3:4i].
- dp  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown, 0 = blanked.
- load  in  1  one-cycle strobe that captures digits/dp/digit_en into staging.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low when driving.
- sseg  out  8  cathodes, active-low, bit order {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - prescaler=0, index=0, pending=0.
  - Staging and active registers all zero, so every digit is blanked.
  - Outputs: an=all 1s, sseg=8'hFF, frame_tick=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1. slot_tick is asserted when the count is REFRESH_DIV-1; the count then wraps to 0.
  - On slot_tick, index advances; from NUM_DIGITS-1 it wraps to 0.
  - frame_wrap = slot_tick AND (index==NUM_DIGITS-1).
- Load / double buffer:
  - load=1: staging captures digits, dp, digit_en; pending=1.
  - frame_wrap with pending=1: active copies staging; pending=0.
  - load and frame_wrap in the same cycle: active takes the live inputs directly (bypass); pending=0.
  - Repeated loads within one frame: the last load wins.
- Output stage:
  - All outputs are registered: 1-cycle latency from the index/active state to an and sseg.
  - Current digit enabled: an has only bit[index] low; sseg = {~dp[index], hexseg(nibble)}.
  - Current digit disabled: an=all 1s, sseg=8'hFF.
  - frame_tick is registered and aligns with the first output cycle of digit 0.
- Hex table (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Reset deasserted mid-scan: restart from index 0 with the prescaler at 0; there is no partial-slot carry-over.
- After reset the display stays blank until the first load has been committed at a frame wrap.

Optional Feature:
SSEG_DIM_EN
- Defined:
  - Adds input bright (4 bits).
  - Within each slot, the anode is driven only while slot_phase < (bright+1)*(REFRESH_DIV/16). Here slot_phase is the prescaler count and the division is an integer floor.
  - Outside that window: an=all 1s, sseg=8'hFF.
  - bright=15 gives full on-time.
  - bright is sampled with the other inputs on load and committed at frame_wrap.
- Not defined: the bright port is absent; the anode is driven for the full slot.

Decomposition:
- Package sseg_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the SEG_OFF (8'hFF) and ANODES_OFF encodings;
  - the segment bit-index constants.
- Sub-module sseg_hex_decoder: combinational nibble-to-7-segment lookup using sseg_pkg.

Test Plan:
- Bench configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=16.
- Reset hold, then release with no load -> an=4'hF, sseg=8'hFF for at least 2 full frames; frame_tick pulses every 64 clocks.
- load with digits=16'h1A08, dp=4'b0001, digit_en=4'hF -> from the next frame_tick:
  - an sequence: E, D, B, 7, 16 clocks each;
  - sseg sequence: 00, C0, 88, F9.
- digit_en=4'b1011 committed -> digit 2 slot shows an=F, sseg=FF; other digits unaffected.
- load pulsed mid-frame with new data -> the old data persists until the wrap; the new data appears exactly in the first digit-0 slot after frame_tick.
- load coincident with frame_wrap -> bypass data shown in the immediately following frame; pending=0, so the next wrap causes no change.
- reset asserted mid-slot at index 2 -> an=F and sseg=FF immediately (asynchronous). After release, a load is required and the scan restarts at index 0.
- SSEG_DIM_EN with bright=3 -> an is low for 4 of every 16 clocks per slot.
